// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared
// register, with a fixed busy/hold window after every committed write.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [7:0]             wr_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PW-1:0]     sel;

    // Scan from the farthest offset back to ptr so the nearest request wins.
    function automatic logic [PW-1:0] pick(input logic [N_REQ-1:0] r,
                                           input logic [PW-1:0] p);
        logic [PW-1:0] s;
        int            idx;
        s = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (r[idx]) s = PW'(idx);
        end
        return s;
    endfunction

    assign sel = pick(req, ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   state_d = (HOLD_CYC > 0) ? HOLD : IDLE;
            HOLD:    if (hold_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        win_d  = win_q;
        hold_d = hold_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        gnt_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) win_d = sel;
            end
            GRANT: begin
                data_d = wdata[int'(win_q)*WIDTH +: WIDTH];
                cnt_d  = cnt_q + 8'd1;
                ptr_d  = (int'(win_q) == N_REQ - 1) ? '0 : win_q + PW'(1);
                hold_d = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
            end
            HOLD: begin
                if (hold_q != '0) hold_d = hold_q - HW'(1);
            end
            default: ;
        endcase
        if (state_d == GRANT) gnt_d[win_d] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign q      = data_q;
    assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed vector table, corner sequences and
// randomized traffic against a cycle-count reference model.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic         busy;
    logic [7:0]   wr_cnt;

    int n_total = 0;
    int n_pass  = 0;

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYC(H)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .q(q), .busy(busy), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] eg,
                           input logic eb, input logic [W-1:0] eq,
                           input logic [7:0] ec);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(ec));
    endtask

    // Reference model: the arbiter is unavailable for 1+H cycles after a
    // grant; the write lands at the end of the first of those cycles.
    int         m_left, m_win, m_ptr;
    bit         m_ingrant;
    logic [7:0] m_q, m_cnt;

    task automatic model_reset();
        m_left = 0; m_win = 0; m_ptr = 0; m_ingrant = 0;
        m_q = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        bit found;
        if (m_left == 0) begin
            if (req != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        m_win = (m_ptr + k) % N;
                        found = 1;
                    end
                end
                m_left = 1 + H;
                m_ingrant = 1;
            end
        end else begin
            if (m_ingrant) begin
                m_q = wdata[m_win*W +: W];
                m_cnt = m_cnt + 8'd1;
                m_ptr = (m_win + 1) % N;
                m_ingrant = 0;
            end
            m_left--;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        chk_all("reset", '0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic         busy;
        logic [W-1:0] q;
        logic [7:0]   cnt;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{4'b0100, 4'b0100, 1'b1, 8'h00, 8'd0};
        vt[1]  = '{4'b0000, 4'b0000, 1'b1, 8'hA5, 8'd1};
        vt[2]  = '{4'b0000, 4'b0000, 1'b1, 8'hA5, 8'd1};
        vt[3]  = '{4'b0000, 4'b0000, 1'b0, 8'hA5, 8'd1};
        vt[4]  = '{4'b1000, 4'b1000, 1'b1, 8'hA5, 8'd1};
        vt[5]  = '{4'b0000, 4'b0000, 1'b1, 8'h11, 8'd2};
        vt[6]  = '{4'b0010, 4'b0000, 1'b1, 8'h11, 8'd2};
        vt[7]  = '{4'b0000, 4'b0000, 1'b0, 8'h11, 8'd2};
        vt[8]  = '{4'b1010, 4'b0010, 1'b1, 8'h11, 8'd2};
        vt[9]  = '{4'b0000, 4'b0000, 1'b1, 8'h22, 8'd3};
        vt[10] = '{4'b0000, 4'b0000, 1'b1, 8'h22, 8'd3};
        vt[11] = '{4'b0000, 4'b0000, 1'b0, 8'h22, 8'd3};
        vt[12] = '{4'b0011, 4'b0001, 1'b1, 8'h22, 8'd3};
        vt[13] = '{4'b0000, 4'b0000, 1'b1, 8'h33, 8'd4};

        do_reset();

        // Directed table: single request, pointer wrap, ignored request.
        wdata = 32'h11_A5_22_33;
        for (int i = 0; i < 14; i++) begin
            req = vt[i].req;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vt[i].gnt, vt[i].busy,
                    vt[i].q, vt[i].cnt);
        end

        // Reset during the GRANT cycle of a 0x3C write.
        req = '0;
        repeat (3) @(negedge clk);
        wdata = 32'h0000_003C;
        req = 4'b0001;
        @(negedge clk);
        chk("midrst.pre_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        #1;
        chk_all("midrst.async", '0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        chk_all("midrst.after", '0, 1'b0, '0, '0);

        // Fairness with all requesters held: grants 4 cycles apart.
        do_reset();
        req = 4'b1111;
        wdata = 32'h44_33_22_11;
        for (int t = 0; t < 17; t++) begin
            @(negedge clk);
            if (t % 4 == 0)
                chk($sformatf("rr.t%0d", t), 32'(gnt),
                    32'(1 << ((t / 4) % 4)));
            else
                chk($sformatf("rr.t%0d", t), 32'(gnt), 32'h0);
        end

        // 256 back-to-back writes wrap the counter.
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            wdata = 32'(8'(i) ^ 8'h5A);
            repeat (4) @(negedge clk);
        end
        req = '0;
        @(negedge clk);
        chk("wrap.cnt", 32'(wr_cnt), 32'h0);
        chk("wrap.q", 32'(q), 32'(8'hFF ^ 8'h5A));

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            wdata = $urandom;
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk_all($sformatf("rand%0d", c),
                    m_ingrant ? N'(1 << m_win) : '0,
                    m_left > 0, m_q, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the register.
REQ-002 Parameter WIDTH, default 8: data width of the shared register.
REQ-003 Parameter HOLD_CYC, default 2: busy cycles after each write (0 allowed).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port req, input, N_REQ: level request per requester. Requester i holds req[i] and its data until gnt[i] is seen.
REQ-007 Port wdata, input, N_REQ*WIDTH: requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 Port gnt, output, N_REQ: registered, one-hot or zero, write-grant strobe.
REQ-009 Port q, output, WIDTH: registered shared register value.
REQ-010 Port busy, output, 1: registered; high in GRANT and HOLD.
REQ-011 Port wr_cnt, output, 8: registered count of committed writes.

Function
REQ-012 FSM states: IDLE, GRANT, HOLD. An internal round-robin pointer ptr has range 0..N_REQ-1.
REQ-013 IDLE: gnt=0 and busy=0. At a rising edge with |req=1, latch the winner and move to GRANT; otherwise stay in IDLE.
REQ-014 Winner selection: first index i with req[i]=1, searched in order ptr, ptr+1, …, wrapping modulo N_REQ.
REQ-015 GRANT lasts exactly 1 cycle, with gnt[winner]=1 and busy=1.
REQ-016 At the rising edge that ends GRANT, all of the following happen together:
- q <= wdata slice of the winner;
- wr_cnt <= wr_cnt+1, wrapping 255->0;
- ptr <= (winner+1) mod N_REQ;
- next state is HOLD if HOLD_CYC>0, else IDLE.
REQ-017 The write commits regardless of req[winner] during GRANT; wdata is sampled only at that edge.
REQ-018 HOLD: gnt=0, busy=1, for exactly HOLD_CYC cycles, then IDLE. req is ignored in GRANT and HOLD.
REQ-019 Request-to-q latency: req sampled in IDLE at edge k; gnt high in cycle k..k+1; q updated at edge k+1.
REQ-020 Minimum spacing between consecutive grants is 2+HOLD_CYC cycles, because IDLE occupies 1 cycle.
REQ-021 q changes only at a GRANT-ending edge or on reset. gnt is never multi-hot.
REQ-022 Simultaneous requests are resolved solely by REQ-014. No requester is starved while it holds req.

Reset
REQ-023 While rst=1, all of the following hold immediately, without a clock edge:
- state=IDLE, ptr=0;
- gnt=0, busy=0;
- q=0, wr_cnt=0.
REQ-024 Reset asserted during GRANT or HOLD aborts the operation. No write commits, and wr_cnt stays 0.
REQ-025 After rst deasserts, the first arbitration occurs at the first rising edge with |req=1.

Verification (N_REQ=4, WIDTH=8, HOLD_CYC=2)
REQ-026 Single request:
- stimulus: after reset, req=0100, wdata slice 2=0xA5;
- response: gnt=0100 for 1 cycle; q=0xA5; wr_cnt=1; busy high 3 cycles.
REQ-027 Round-robin fairness:
- stimulus: req=1111 held after reset;
- response: gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 4 cycles apart.
REQ-028 Pointer wrap:
- stimulus: grant to requester 3 (ptr becomes 0), then req=1010;
- response: gnt=0010.
- stimulus: grant to requester 1 (ptr=2), then req=0011;
- response: gnt=0001.
REQ-029 Reset mid-operation:
- stimulus: rst pulses during the GRANT cycle of a 0x3C write;
- response: gnt=0, busy=0, q=0x00 and wr_cnt=0 immediately, and they remain so after release.
REQ-030 Counter wrap:
- stimulus: 256 back-to-back writes;
- response: wr_cnt=0; q equals the last written data.
REQ-031 Ignored request:
- stimulus: req[1] asserted only during the HOLD cycles and dropped before IDLE;
- response: no grant to requester 1.
